alu_ctrl_mc: RTL
================

Name: alu_ctrl_mc

Overview:
- Registered, parametrised ALU-control stage for the MIPS pipeline, at the ID/EX boundary.
- Decodes alu_op plus funct/opcode into a 5-bit ALU control code and registers it with valid/stall/flush handling.
- Adds I-type and store decoding, plus an explicit illegal flag.
- Sequences the multi-cycle multiply/divide unit through a busy FSM and raises a hazard stall for dependent HI/LO accesses.

Parameters:
- N_BITS, 6: funct/opcode field width.
- N_BITS_OP, 3: alu_op width.
- N_BITS_CTRL, 5: ALU control code width.
- MD_LATENCY, 32: mult/div busy cycles; must be >= 2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  decode-stage instruction valid.
- i_alu_op  in  N_BITS_OP  operation class from main control.
- i_funcion  in  N_BITS  funct (R-type) or opcode (mem/I-type).
- i_stall  in  1  downstream hold; output registers keep their value.
- i_flush  in  1  squash; next o_valid = 0.
- o_valid  out  1  registered output valid.
- o_alu_ctrl  out  N_BITS_CTRL  registered ALU control code.
- o_illegal  out  1  registered: unsupported encoding.
- o_md_start  out  1  one-cycle pulse that launches mult/div.
- o_md_busy  out  1  mult/div in flight.
- o_hilo_we  out  1  one-cycle HI/LO write enable.
- o_stall_req  out  1  combinational hazard request to hazard unit.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: all outputs 0, o_alu_ctrl = 00000, FSM = IDLE, counter = 0. A reset mid-mult/div aborts it; no o_hilo_we is issued.
- Control codes (package constants):
  - AND 00000, OR 00001, ADD 00010, ADDU 00011, NOR 00100, XOR 00101.
  - SLL 00110, SUB 00111, SUBU 01000, SLT 01001, SRL 01010, SRA 01011.
  - LUI 01100, LB 01101, LH 01110, LBU 01111, LHU 10000.
  - SRAV 10001, SLLV 10010, SRLV 10011, SLTU 10100.
  - MULT 10101, MULTU 10110, DIV 10111, DIVU 11000, MFHI 11001, MFLO 11010.
  - INVALID 11111.
- Decode when alu_op = 000 (memory; field is the opcode):
  - lb 100000 -> LB, lh 100001 -> LH, lw 100011 -> ADD, lbu 100100 -> LBU, lhu 100101 -> LHU, lwu 100111 -> ADDU.
  - sb/sh/sw (101000/101001/101011) -> ADD.
- Decode when alu_op = 001 (branch): SUB.
- Decode when alu_op = 010 (R-type funct):
  - 100100 AND, 100101 OR, 100000 ADD, 100001 ADDU, 100111 NOR, 100110 XOR.
  - 000000 SLL, 000100 SLLV, 000010 SRL, 000110 SRLV, 000011 SRA, 000111 SRAV.
  - 100010 SUB, 100011 SUBU, 101010 SLT, 101011 SLTU.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO.
- Decode when alu_op = 011 (I-type opcode): 001000 ADD, 001001 ADDU, 001010 SLT, 001011 SLTU, 001100 AND, 001101 OR, 001110 XOR, 001111 LUI.
- Any other alu_op or funct: INVALID with illegal = 1; never aliases a legal code.
- Latency: one cycle from i_valid to o_valid.
- Output register priority per edge, highest first: reset > flush > stall > hazard > capture.
  - flush: o_valid <= 0; other fields don't care.
  - stall: hold all output registers.
  - hazard (o_stall_req = 1): bubble, o_valid <= 0.
  - capture: o_valid <= i_valid, and code/illegal are loaded.
- Flush and stall asserted together: flush wins.
- md-class ops: MULT, MULTU, DIV, DIVU. hilo-class ops: md-class plus MFHI and MFLO.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on capture of a valid md-class op. On the same edge: o_md_start <= 1 for one cycle, counter <= MD_LATENCY-1.
  - BUSY: counter decrements every edge, including while i_stall = 1. Counter = 0 moves to DONE.
  - DONE: o_hilo_we = 1 for exactly one cycle, then IDLE.
  - o_md_busy = 1 in BUSY and DONE; the busy window is MD_LATENCY+1 cycles.
  - i_flush does not affect the FSM, because the md op has already issued.
- o_stall_req = i_valid & decoded op is hilo-class & state != IDLE.
  - Non-hilo ops pass freely while BUSY/DONE.
  - o_stall_req is never asserted in IDLE.
- Counter width: $clog2(MD_LATENCY).

Decomposition:
- Package alu_ctrl_pkg holds:
  - the control-code localparams listed above;
  - alu_op class constants MEM = 000, BR = 001, RTYPE = 010, ITYPE = 011;
  - the FSM state encoding.
- One sub-module, alu_ctrl_dec: purely combinational decoder (alu_op, funct -> code, illegal, is_md, is_hilo).
- The top level holds the output registers, the FSM, the counter and the hazard logic.

Test Plan:
- Reset: hold i_reset 2 cycles with i_valid = 1 and funct = 100100 -> every output 0; o_alu_ctrl = 00000 throughout.
- Decode sweep: (010, 100100) -> 00000; (011, 001111) -> 01100; (000, 100101) -> 10000; (001, any) -> 00111. Each appears one cycle later with o_valid = 1 and o_illegal = 0.
- Illegal: (010, 111111) and (111, 000000) -> o_alu_ctrl = 11111, o_illegal = 1, o_valid = 1.
- MD_LATENCY = 4 MULT, then MFHI on the next cycle:
  - o_md_start pulses once; o_md_busy is high 5 cycles; o_hilo_we is high in the 5th cycle only.
  - o_stall_req is high and o_valid is 0 for the MFHI while busy.
  - MFHI is captured the cycle after DONE.
  - An interleaved ADD during BUSY passes with no stall.
- i_stall and i_flush asserted together with valid ADD input -> o_valid = 0. With i_stall alone, all outputs hold for 3 cycles, and during a mult the counter still expires on time.
- Reset asserted mid-BUSY -> FSM returns to IDLE, o_md_busy = 0 next cycle, and o_hilo_we never pulses.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU-control stage:
//   - 5-bit ALU control codes
//   - alu_op class encodings
//   - mult/div FSM state type
//   - small classification helpers
package alu_ctrl_pkg;

  localparam int unsigned CTRL_W = 5;

  localparam logic [CTRL_W-1:0] CTRL_AND     = 5'b00000;
  localparam logic [CTRL_W-1:0] CTRL_OR      = 5'b00001;
  localparam logic [CTRL_W-1:0] CTRL_ADD     = 5'b00010;
  localparam logic [CTRL_W-1:0] CTRL_ADDU    = 5'b00011;
  localparam logic [CTRL_W-1:0] CTRL_NOR     = 5'b00100;
  localparam logic [CTRL_W-1:0] CTRL_XOR     = 5'b00101;
  localparam logic [CTRL_W-1:0] CTRL_SLL     = 5'b00110;
  localparam logic [CTRL_W-1:0] CTRL_SUB     = 5'b00111;
  localparam logic [CTRL_W-1:0] CTRL_SUBU    = 5'b01000;
  localparam logic [CTRL_W-1:0] CTRL_SLT     = 5'b01001;
  localparam logic [CTRL_W-1:0] CTRL_SRL     = 5'b01010;
  localparam logic [CTRL_W-1:0] CTRL_SRA     = 5'b01011;
  localparam logic [CTRL_W-1:0] CTRL_LUI     = 5'b01100;
  localparam logic [CTRL_W-1:0] CTRL_LB      = 5'b01101;
  localparam logic [CTRL_W-1:0] CTRL_LH      = 5'b01110;
  localparam logic [CTRL_W-1:0] CTRL_LBU     = 5'b01111;
  localparam logic [CTRL_W-1:0] CTRL_LHU     = 5'b10000;
  localparam logic [CTRL_W-1:0] CTRL_SRAV    = 5'b10001;
  localparam logic [CTRL_W-1:0] CTRL_SLLV    = 5'b10010;
  localparam logic [CTRL_W-1:0] CTRL_SRLV    = 5'b10011;
  localparam logic [CTRL_W-1:0] CTRL_SLTU    = 5'b10100;
  localparam logic [CTRL_W-1:0] CTRL_MULT    = 5'b10101;
  localparam logic [CTRL_W-1:0] CTRL_MULTU   = 5'b10110;
  localparam logic [CTRL_W-1:0] CTRL_DIV     = 5'b10111;
  localparam logic [CTRL_W-1:0] CTRL_DIVU    = 5'b11000;
  localparam logic [CTRL_W-1:0] CTRL_MFHI    = 5'b11001;
  localparam logic [CTRL_W-1:0] CTRL_MFLO    = 5'b11010;
  localparam logic [CTRL_W-1:0] CTRL_INVALID = 5'b11111;

  localparam logic [2:0] ALU_OP_MEM   = 3'b000;
  localparam logic [2:0] ALU_OP_BR    = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OP_ITYPE = 3'b011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

  // Ops that occupy the multi-cycle mult/div unit.
  function automatic logic is_md_code(input logic [CTRL_W-1:0] code);
    return (code == CTRL_MULT) || (code == CTRL_MULTU) ||
           (code == CTRL_DIV)  || (code == CTRL_DIVU);
  endfunction

  // Ops that touch HI/LO and must wait for an in-flight mult/div.
  function automatic logic is_hilo_code(input logic [CTRL_W-1:0] code);
    return is_md_code(code) || (code == CTRL_MFHI) || (code == CTRL_MFLO);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decoder.
//   alu_op  : operation class from main control
//   funct   : R-type funct or mem/I-type opcode
//   code    : ALU control code (INVALID for unsupported encodings)
//   illegal : encoding not supported
//   is_md   : op launches the mult/div unit
//   is_hilo : op reads or writes HI/LO
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS      = 6,
  parameter int unsigned N_BITS_OP   = 3,
  parameter int unsigned N_BITS_CTRL = 5
) (
  input  logic [N_BITS_OP-1:0]   alu_op,
  input  logic [N_BITS-1:0]      funct,
  output logic [N_BITS_CTRL-1:0] code,
  output logic                   illegal,
  output logic                   is_md,
  output logic                   is_hilo
);

  logic [CTRL_W-1:0] code_raw;

  always_comb begin
    code_raw = CTRL_INVALID;
    case (alu_op)
      ALU_OP_MEM: begin
        case (funct)
          6'b100000: code_raw = CTRL_LB;
          6'b100001: code_raw = CTRL_LH;
          6'b100011: code_raw = CTRL_ADD;
          6'b100100: code_raw = CTRL_LBU;
          6'b100101: code_raw = CTRL_LHU;
          6'b100111: code_raw = CTRL_ADDU;
          6'b101000: code_raw = CTRL_ADD;
          6'b101001: code_raw = CTRL_ADD;
          6'b101011: code_raw = CTRL_ADD;
          default:   code_raw = CTRL_INVALID;
        endcase
      end
      ALU_OP_BR: code_raw = CTRL_SUB;
      ALU_OP_RTYPE: begin
        case (funct)
          6'b100100: code_raw = CTRL_AND;
          6'b100101: code_raw = CTRL_OR;
          6'b100000: code_raw = CTRL_ADD;
          6'b100001: code_raw = CTRL_ADDU;
          6'b100111: code_raw = CTRL_NOR;
          6'b100110: code_raw = CTRL_XOR;
          6'b000000: code_raw = CTRL_SLL;
          6'b000100: code_raw = CTRL_SLLV;
          6'b000010: code_raw = CTRL_SRL;
          6'b000110: code_raw = CTRL_SRLV;
          6'b000011: code_raw = CTRL_SRA;
          6'b000111: code_raw = CTRL_SRAV;
          6'b100010: code_raw = CTRL_SUB;
          6'b100011: code_raw = CTRL_SUBU;
          6'b101010: code_raw = CTRL_SLT;
          6'b101011: code_raw = CTRL_SLTU;
          6'b011000: code_raw = CTRL_MULT;
          6'b011001: code_raw = CTRL_MULTU;
          6'b011010: code_raw = CTRL_DIV;
          6'b011011: code_raw = CTRL_DIVU;
          6'b010000: code_raw = CTRL_MFHI;
          6'b010010: code_raw = CTRL_MFLO;
          default:   code_raw = CTRL_INVALID;
        endcase
      end
      ALU_OP_ITYPE: begin
        case (funct)
          6'b001000: code_raw = CTRL_ADD;
          6'b001001: code_raw = CTRL_ADDU;
          6'b001010: code_raw = CTRL_SLT;
          6'b001011: code_raw = CTRL_SLTU;
          6'b001100: code_raw = CTRL_AND;
          6'b001101: code_raw = CTRL_OR;
          6'b001110: code_raw = CTRL_XOR;
          6'b001111: code_raw = CTRL_LUI;
          default:   code_raw = CTRL_INVALID;
        endcase
      end
      default: code_raw = CTRL_INVALID;
    endcase
  end

  // INVALID is reserved: no legal op decodes to it, so it doubles as the illegal flag.
  assign illegal = (code_raw == CTRL_INVALID);
  assign is_md   = is_md_code(code_raw);
  assign is_hilo = is_hilo_code(code_raw);
  assign code    = N_BITS_CTRL'(code_raw);

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered ALU-control stage at the ID/EX boundary with mult/div sequencing.
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_valid           : decode-stage instruction valid
//   i_alu_op, i_funcion : operation class and funct/opcode field
//   i_stall, i_flush  : downstream hold / squash
//   o_valid, o_alu_ctrl, o_illegal : registered decode result
//   o_md_start        : one-cycle launch pulse for mult/div
//   o_md_busy         : mult/div in flight (BUSY or DONE)
//   o_hilo_we         : one-cycle HI/LO write enable (DONE)
//   o_stall_req       : combinational HI/LO hazard request
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS      = 6,
  parameter int unsigned N_BITS_OP   = 3,
  parameter int unsigned N_BITS_CTRL = 5,
  parameter int unsigned MD_LATENCY  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [N_BITS_OP-1:0]   i_alu_op,
  input  logic [N_BITS-1:0]      i_funcion,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [N_BITS_CTRL-1:0] o_alu_ctrl,
  output logic                   o_illegal,
  output logic                   o_md_start,
  output logic                   o_md_busy,
  output logic                   o_hilo_we,
  output logic                   o_stall_req
);

  localparam int unsigned CntW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  logic [N_BITS_CTRL-1:0] dec_code;
  logic                   dec_illegal;
  logic                   dec_is_md;
  logic                   dec_is_hilo;

  md_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   md_start_q, md_start_d;

  logic                   valid_q;
  logic [N_BITS_CTRL-1:0] ctrl_q;
  logic                   illegal_q;

  logic                   stall_req;
  logic                   capture;
  logic                   launch;

  alu_ctrl_dec #(
    .N_BITS      (N_BITS),
    .N_BITS_OP   (N_BITS_OP),
    .N_BITS_CTRL (N_BITS_CTRL)
  ) u_dec (
    .alu_op  (i_alu_op),
    .funct   (i_funcion),
    .code    (dec_code),
    .illegal (dec_illegal),
    .is_md   (dec_is_md),
    .is_hilo (dec_is_hilo)
  );

  assign stall_req = i_valid & dec_is_hilo & (state_q != StIdle);
  assign capture   = ~i_flush & ~i_stall & ~stall_req;
  // An md op while not idle is already blocked by stall_req; the state term is belt and braces.
  assign launch    = capture & i_valid & dec_is_md & (state_q == StIdle);

  // Output registers: reset > flush > stall > hazard > capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (i_flush) begin
      valid_q   <= 1'b0;
    end else if (!i_stall) begin
      if (stall_req) begin
        valid_q   <= 1'b0;
      end else begin
        valid_q   <= i_valid;
        ctrl_q    <= dec_code;
        illegal_q <= dec_illegal;
      end
    end
  end

  // Mult/div sequencer. The counter keeps running under i_stall and i_flush:
  // once launched the unit is committed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) begin
          state_d    = StBusy;
          cnt_d      = CntW'(MD_LATENCY - 1);
          md_start_d = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_ctrl  = ctrl_q;
  assign o_illegal   = illegal_q;
  assign o_md_start  = md_start_q;
  assign o_md_busy   = (state_q != StIdle);
  assign o_hilo_we   = (state_q == StDone);
  assign o_stall_req = stall_req;

endmodule
